// File: rtl/proc_pkg.sv
// Shared fetch-side types and constants for the instruction fetch queue.
package proc_pkg;

  localparam int IFQ_MAX_XLEN = 32;
  localparam int IFQ_PC_STEP  = 4;

  typedef struct packed {
    logic [IFQ_MAX_XLEN-1:0] pc;
    logic [IFQ_MAX_XLEN-1:0] inst;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular entry store for the fetch queue: storage array, read/write pointers and occupancy.
module ifq_fifo
  import proc_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = ifq_entry_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  T              push_data_i,
  input  logic          pop_i,
  output T              head_o,
  output logic [CW-1:0] count_o
);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) begin
        r_mem[r_wr_ptr] <= push_data_i;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (pop_i) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-limited request issue, in-order response capture,
// and flush-and-refetch on redirect with accounting for responses still in flight.
module ifetch_queue
  import proc_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            im_req_o,
  output logic [XLEN-1:0] im_addr_o,
  input  logic            im_ack_i,
  input  logic            im_rvalid_i,
  input  logic [XLEN-1:0] im_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i
);

  localparam int FW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(DEPTH) + 2;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ifetch_queue: DEPTH must be a power of two in 2..16");
  end
  if (XLEN > IFQ_MAX_XLEN) begin : g_bad_xlen
    $error("ifetch_queue: XLEN exceeds the width of ifq_entry_t");
  end

  logic [XLEN-1:0] r_fpc;
  logic [XLEN-1:0] r_rpc;
  logic [CW-1:0]   r_live;
  logic [CW-1:0]   r_drop;
  logic            r_run;
  logic [CW-1:0]   w_live_nxt;
  logic [CW-1:0]   w_drop_nxt;
  logic            w_fire;
  logic            w_push;
  logic            w_pop;
  logic            w_credit_ok;
  logic [FW-1:0]   w_count;
  ifq_entry_t      w_push_entry;
  ifq_entry_t      w_head;

  // Every queue slot is either occupied, awaited, or owed to a discarded response.
  assign w_credit_ok  = (CW'(w_count) + r_live + r_drop) < CW'(DEPTH);
  assign im_req_o     = r_run & ~redirect_i & w_credit_ok;
  assign im_addr_o    = r_fpc;
  assign w_fire       = im_req_o & im_ack_i;
  assign inst_valid_o = (w_count != '0);
  assign w_pop        = inst_valid_o & inst_ready_i & ~redirect_i;

  always_comb begin
    w_live_nxt = r_live;
    w_drop_nxt = r_drop;
    w_push     = 1'b0;
    if (redirect_i) begin
      w_drop_nxt = r_drop + r_live + CW'(w_fire);
      w_live_nxt = '0;
      if (im_rvalid_i && (w_drop_nxt != '0)) w_drop_nxt = w_drop_nxt - CW'(1);
    end else begin
      if (im_rvalid_i) begin
        if (r_drop != '0) begin
          w_drop_nxt = r_drop - CW'(1);
        end else if (r_live != '0) begin
          w_push     = 1'b1;
          w_live_nxt = r_live - CW'(1);
        end
      end
      if (w_fire) w_live_nxt = w_live_nxt + CW'(1);
    end
  end

  // r_rpc tracks the address of the oldest kept request, i.e. the next pushed entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_run  <= 1'b0;
      r_fpc  <= RESET_PC;
      r_rpc  <= RESET_PC;
      r_live <= '0;
      r_drop <= '0;
    end else begin
      r_run  <= 1'b1;
      r_live <= w_live_nxt;
      r_drop <= w_drop_nxt;
      if (redirect_i) begin
        r_fpc <= redirect_pc_i;
        r_rpc <= redirect_pc_i;
      end else begin
        if (w_fire) r_fpc <= r_fpc + XLEN'(IFQ_PC_STEP);
        if (w_push) r_rpc <= r_rpc + XLEN'(IFQ_PC_STEP);
      end
    end
  end

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.pc   = IFQ_MAX_XLEN'(r_rpc);
    w_push_entry.inst = IFQ_MAX_XLEN'(im_rdata_i);
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .T     (ifq_entry_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (redirect_i),
    .push_i      (w_push),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .count_o     (w_count)
  );

  assign inst_o    = w_head.inst[XLEN-1:0];
  assign inst_pc_o = w_head.pc[XLEN-1:0];

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a memory model answers acked fetches in order, and a
// negedge monitor checks fetch addresses and delivered instructions against expected queues.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  // Stimulus-side controls for the memory and ack models.
  logic        mem_en;
  logic        spur;
  logic        ack_force;
  int          ack_budget;

  logic [31:0] req_exp_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] resp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  ifetch_queue #(
    .DEPTH    (4),
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .im_req_o      (im_req),
    .im_addr_o     (im_addr),
    .im_ack_i      (im_ack),
    .im_rvalid_i   (im_rvalid),
    .im_rdata_i    (im_rdata),
    .inst_valid_o  (inst_valid),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .inst_ready_i  (inst_ready)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_fetch(input logic [31:0] addr);
    req_exp_q.push_back(addr);
  endtask

  task automatic expect_inst(input logic [31:0] addr);
    exp_q.push_back({addr, mem_word(addr)});
  endtask

  task automatic expect_both(input logic [31:0] base, input int n);
    logic [31:0] a;
    a = base;
    for (int i = 0; i < n; i++) begin
      expect_fetch(a);
      expect_inst(a);
      a = a + 32'd4;
    end
  endtask

  // ---------------- memory model: one in-order response per cycle ----------------
  initial begin
    logic [31:0] a;
    im_rvalid = 1'b0;
    im_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (spur) begin
        im_rvalid = 1'b1;
        im_rdata  = 32'hBAD0_0BAD;
      end else if (mem_en && resp_q.size() > 0) begin
        a         = resp_q.pop_front();
        im_rvalid = 1'b1;
        im_rdata  = mem_word(a);
      end else begin
        im_rvalid = 1'b0;
        im_rdata  = '0;
      end
    end
  end

  // ---------------- ack driver: acks up to ack_budget presented requests ----------------
  initial begin
    im_ack = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (ack_force) begin
        im_ack = 1'b1;
      end else if (ack_budget > 0 && im_req) begin
        im_ack = 1'b1;
        ack_budget--;
      end else begin
        im_ack = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (im_req && im_ack) begin
        resp_q.push_back(im_addr);
        if (req_exp_q.size() == 0) flag_unexpected("fetch_addr", 64'(im_addr));
        else check("fetch_addr", 64'(im_addr), 64'(req_exp_q.pop_front()));
      end
      if (!redirect && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          flag_unexpected("inst_pc", 64'(inst_pc));
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("inst_pc", 64'(inst_pc), 64'(e[63:32]));
          check("inst_word", 64'(inst), 64'(e[31:0]));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #50000;
    n_errors++;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b0;
    mem_en      = 1'b1;
    spur        = 1'b0;
    ack_force   = 1'b0;
    ack_budget  = 0;

    tick(2);
    check("rst_req", 64'(im_req), 64'd0);
    check("rst_addr", 64'(im_addr), 64'h0);
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst", 64'(inst), 64'h0);
    check("rst_inst_pc", 64'(inst_pc), 64'h0);
    rst_n = 1'b1;

    // Streaming from reset: fetches 0,4,8,12 with one-cycle response latency.
    inst_ready = 1'b1;
    expect_both(32'h0, 4);
    ack_budget = 4;
    tick(12);

    // Stalled decode: exactly four fetches fill the queue, then requests stop.
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) expect_fetch(32'd16 + 32'(4 * i));
    ack_budget = 8;
    tick(10);
    check("full_req_low", 64'(im_req), 64'd0);
    check("full_valid", 64'(inst_valid), 64'd1);
    ack_budget = 0;
    expect_fetch(32'd32);
    expect_inst(32'd16);
    ack_budget = 1;
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;
    tick(6);
    check("refill_req_low", 64'(im_req), 64'd0);
    check("head_after_pop", 64'(inst_pc), 64'd20);
    ack_budget = 0;

    // Drain and stream 20 more fetches with an intermittent stall; pc stays continuous across pointer wrap.
    for (int i = 0; i < 4; i++) expect_inst(32'd20 + 32'(4 * i));
    expect_both(32'd36, 20);
    ack_budget = 20;
    for (int i = 0; i < 60; i++) begin
      inst_ready = (i % 4 != 3);
      tick(1);
    end
    inst_ready = 1'b1;
    tick(4);

    // Two responses in flight when redirected to 0x100: both must be dropped.
    mem_en = 1'b0;
    expect_fetch(32'd116);
    expect_fetch(32'd120);
    ack_budget = 2;
    tick(4);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    #1 check("redir1_req_low", 64'(im_req), 64'd0);
    tick(1);
    redirect = 1'b0;
    expect_both(32'h0000_0100, 2);
    ack_budget = 2;
    mem_en     = 1'b1;
    tick(10);

    // Redirect with queued stale entries, a forced ack and a response in the same cycle.
    inst_ready = 1'b0;
    expect_fetch(32'h0000_0108);
    expect_fetch(32'h0000_010C);
    ack_budget = 2;
    tick(6);
    check("stale_present", 64'(inst_valid), 64'd1);
    mem_en = 1'b0;
    expect_fetch(32'h0000_0110);
    ack_budget = 1;
    tick(3);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    ack_force   = 1'b1;
    mem_en      = 1'b1;
    #1 check("redir2_req_low", 64'(im_req), 64'd0);
    tick(1);
    redirect  = 1'b0;
    ack_force = 1'b0;
    #1 check("post_redir_valid", 64'(inst_valid), 64'd0);
    inst_ready = 1'b1;
    expect_both(32'h0000_0200, 2);
    ack_budget = 2;
    tick(10);

    // Back-to-back redirects: only the second target is fetched.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    expect_both(32'h0000_0400, 1);
    ack_budget = 1;
    tick(1);
    redirect_pc = 32'h0000_0400;
    tick(1);
    redirect = 1'b0;
    tick(6);

    // Fetch address wraps from the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    expect_both(32'hFFFF_FFFC, 2);
    ack_budget = 2;
    tick(1);
    redirect = 1'b0;
    tick(8);

    // A response with nothing outstanding is ignored.
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    tick(4);
    check("spur_ignored", 64'(inst_valid), 64'd0);

    // Reset with a request outstanding; memory forgets it too.
    mem_en = 1'b0;
    expect_fetch(32'h0000_0004);
    ack_budget = 1;
    tick(3);
    rst_n = 1'b0;
    resp_q.delete();
    ack_budget = 0;
    #1;
    check("mid_rst_req", 64'(im_req), 64'd0);
    check("mid_rst_addr", 64'(im_addr), 64'h0);
    check("mid_rst_valid", 64'(inst_valid), 64'd0);
    tick(1);
    rst_n  = 1'b1;
    mem_en = 1'b1;
    expect_both(32'h0, 1);
    ack_budget = 1;
    tick(8);

    tick(4);
    check("inst_q_drained", 64'(exp_q.size()), 64'd0);
    check("fetch_q_drained", 64'(req_exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: queue entries; power of two, 2..16; elaboration error otherwise.
REQ-002 SHALL have parameter XLEN, default 32: address and instruction width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n_i  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port redirect_i  input  1  branch, jump, exception or return taken; flush and refetch.
REQ-007 SHALL have port redirect_pc_i  input  XLEN  new fetch address, valid with redirect_i.
REQ-008 SHALL have port im_req_o  output  1  fetch request to instruction memory.
REQ-009 SHALL have port im_addr_o  output  XLEN  fetch address, valid with im_req_o.
REQ-010 SHALL have port im_ack_i  input  1  memory accepts the request this cycle.
REQ-011 SHALL have port im_rvalid_i  input  1  read data returned; responses are in request order.
REQ-012 SHALL have port im_rdata_i  input  XLEN  returned instruction word.
REQ-013 SHALL have port inst_valid_o  output  1  head entry available to decode.
REQ-014 SHALL have port inst_o  output  XLEN  head instruction.
REQ-015 SHALL have port inst_pc_o  output  XLEN  address of head instruction.
REQ-016 SHALL have port inst_ready_i  input  1  decode consumes head; low means stall.

Function
REQ-017 SHALL keep fetch pointer fpc; a request completes when im_req_o and im_ack_i are both high, and fpc then advances by 4, wrapping modulo 2^XLEN.
REQ-018 SHALL hold im_req_o and im_addr_o stable until acked, unless redirect_i is high.
REQ-019 SHALL assert im_req_o only when count + live + drop < DEPTH, where count is queue occupancy, live is outstanding kept requests and drop is outstanding discarded requests.
REQ-020 SHALL write an im_rvalid_i response with drop==0 into the tail entry with its pc; live decrements.
REQ-021 SHALL discard an im_rvalid_i response with drop>0; drop decrements.
REQ-022 SHALL drive inst_valid_o = (count>0); inst_o and inst_pc_o come from registered head storage, with no bypass.
REQ-023 SHALL make a pushed entry visible one cycle after its im_rvalid_i.
REQ-024 SHALL pop the head when inst_valid_o and inst_ready_i are both high.
REQ-025 SHALL allow push and pop in the same cycle, including when full, leaving count unchanged.
REQ-026 SHALL wrap read and write pointers modulo DEPTH.
REQ-027 SHALL, on redirect_i, with priority over push, pop and ack:
- set count to 0;
- set fpc to redirect_pc_i;
- set drop to drop + live, plus 1 if a request is acked this cycle;
- set live to 0;
- discard any im_rvalid_i arriving in that cycle by decrementing the new drop.
REQ-028 SHALL hold im_req_o low in the redirect cycle and SHALL resume requests at redirect_pc_i on the next cycle.
REQ-029 SHALL let a redirect during the cycle after a redirect override the first; only the last redirect address is fetched.
REQ-030 SHALL hold inst_valid_o low the cycle after redirect; downstream ignores inst_valid_o during the redirect cycle itself.
REQ-031 SHALL have no error states: an im_rvalid_i with live==drop==0 is ignored.

Reset
REQ-032 SHALL, with rst_n_i low, immediately set im_req_o=0, im_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0, count=live=drop=0 and pointers=0.
REQ-033 SHALL raise im_req_o the first cycle after rst_n_i deasserts; reset during outstanding requests forgets them, and memory is reset together.

Structure
REQ-034 SHALL take from proc_pkg the typedef ifq_entry_t (pc and inst fields) and the constant IFQ_PC_STEP = 4.
REQ-035 SHALL place the storage array with pointers and count in one sub-module ifq_fifo, parametrised by DEPTH and entry type; credit, drop and fpc logic stay in ifetch_queue.

Verification
REQ-036 SHALL cover: reset, then im_ack_i=1 and im_rvalid_i one cycle later -> addresses 0,4,8,12; inst_pc_o sequence 0,4,8,12 with matching im_rdata_i.
REQ-037 SHALL cover: DEPTH=4 with inst_ready_i=0 -> exactly 4 requests acked, then im_req_o stays low; one pop -> exactly one new request.
REQ-038 SHALL cover: 2 outstanding requests plus redirect_i to 0x100 -> next 2 responses dropped; first visible inst_pc_o=0x100.
REQ-039 SHALL cover: redirect in the same cycle as an ack and an im_rvalid_i -> drop accounting correct; no stale instruction reaches decode.
REQ-040 SHALL cover: full queue with simultaneous push and pop for 20 cycles -> count stays 4; pc values continuous across pointer wrap.
REQ-041 SHALL cover: redirect_pc_i=0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000.
